// File: rtl/cve2_obi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : cve2_obi_mem_responder
// Brief   : OBI req/gnt/rvalid word SRAM responder with grant stall, fixed
//           in-order response latency, outstanding limit and range errors.
//           Define CVE2_OBI_ERR_INJECT_EN to add err_inject_i (forced errors).
// Rev     : 1.0  initial release
// ============================================================================
module cve2_obi_mem_responder #(
   parameter int unsigned MemWords       = 1024,
   parameter logic [31:0] BaseAddr       = 32'h0,
   parameter int unsigned GntStall       = 0,
   parameter int unsigned RspLatency     = 1,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
`ifdef CVE2_OBI_ERR_INJECT_EN
   input  logic        err_inject_i,
`endif
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   localparam int unsigned c_IDX_W   = $clog2(MemWords);
   localparam int unsigned c_STALL_W = (GntStall > 0) ? $clog2(GntStall + 1) : 1;
   localparam int unsigned c_OUT_W   = $clog2(MaxOutstanding + 1);
   localparam logic [c_STALL_W-1:0] c_STALL_MAX = c_STALL_W'(GntStall);
   localparam logic [c_OUT_W-1:0]   c_OUT_MAX   = c_OUT_W'(MaxOutstanding);
   localparam logic [32:0]          c_SPAN      = 33'(4 * MemWords);

   logic [31:0]          mem_q [MemWords];
   logic [c_STALL_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [c_OUT_W-1:0]   out_cnt_q, out_cnt_d;
   logic [RspLatency-1:0] pipe_vld_q;
   logic [RspLatency-1:0] pipe_err_q;
   logic [31:0]          pipe_data_q [RspLatency];

   logic [32:0]          diff;
   logic [c_IDX_W-1:0]   idx;
   logic                 in_range;
   logic                 inject;
   logic                 accept;
   logic                 rsp_err;
   logic                 mem_we;
   logic [31:0]          rsp_data;

   // A 33-bit difference makes addresses below BaseAddr look huge, so one compare covers both bounds.
   assign diff     = {1'b0, addr_i} - {1'b0, BaseAddr};
   assign in_range = (diff < c_SPAN);
   assign idx      = diff[c_IDX_W+1:2];

`ifdef CVE2_OBI_ERR_INJECT_EN
   assign inject = err_inject_i;
`else
   assign inject = 1'b0;
`endif

   assign gnt_o    = ~rst_i & req_i & (stall_cnt_q == c_STALL_MAX) & (out_cnt_q < c_OUT_MAX);
   assign accept   = req_i & gnt_o;
   assign rsp_err  = ~in_range | inject;
   assign mem_we   = accept & we_i & ~rsp_err;
   assign rsp_data = (accept & ~we_i & ~rsp_err) ? mem_q[idx] : 32'h0;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!req_i || accept) begin
         stall_cnt_d = '0;
      end else if (stall_cnt_q != c_STALL_MAX) begin
         stall_cnt_d = stall_cnt_q + c_STALL_W'(1);
      end
   end

   always_comb begin
      out_cnt_d = out_cnt_q;
      if (accept && !rvalid_o) begin
         out_cnt_d = out_cnt_q + c_OUT_W'(1);
      end else if (!accept && rvalid_o) begin
         out_cnt_d = out_cnt_q - c_OUT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
         out_cnt_q   <= '0;
         pipe_vld_q  <= '0;
         pipe_err_q  <= '0;
         for (int i = 0; i < int'(RspLatency); i++) begin
            pipe_data_q[i] <= '0;
         end
      end else begin
         stall_cnt_q    <= stall_cnt_d;
         out_cnt_q      <= out_cnt_d;
         pipe_vld_q[0]  <= accept;
         pipe_err_q[0]  <= accept & rsp_err;
         pipe_data_q[0] <= rsp_data;
         for (int i = 1; i < int'(RspLatency); i++) begin
            pipe_vld_q[i]  <= pipe_vld_q[i-1];
            pipe_err_q[i]  <= pipe_err_q[i-1];
            pipe_data_q[i] <= pipe_data_q[i-1];
         end
      end
   end

   // Storage is deliberately left out of reset so contents survive rst_i.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int k = 0; k < 4; k++) begin
            if (be_i[k]) begin
               mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
            end
         end
      end
   end

   assign rvalid_o = pipe_vld_q[RspLatency-1];
   assign err_o    = pipe_err_q[RspLatency-1];
   assign rdata_o  = pipe_data_q[RspLatency-1];

endmodule
`default_nettype wire
